// File: rtl/vex_issue_ctrl_pkg.sv
// Shared vector-issue types: register-file sizing and the writeback slot entry.
package vex_issue_ctrl_pkg;

  localparam int VREG_COUNT = 32;
  localparam int VREG_ADDR  = 5;

  typedef logic [VREG_ADDR-1:0] vreg_t;

  typedef struct packed {
    logic  vld;
    vreg_t dest;
  } slot_t;

endpackage

// File: rtl/vex_issue_ctrl_if.sv
// Micro-op handshake into the issue controller, plus the outstanding-load hint.
interface vex_issue_ctrl_if
  import vex_issue_ctrl_pkg::*;
#(
  parameter int MICROOP_BIT = 9
);
  logic                   in_valid;
  logic                   in_ready;
  logic [MICROOP_BIT-1:0] in_alu_op;
  vreg_t                  in_dest;
  vreg_t                  in_src1;
  vreg_t                  in_src2;
  vreg_t                  in_src3;
  logic [2:0]             in_src_en;
  logic                   in_mul;
  logic                   wait_load_signal;
  vreg_t                  load_destination;

  modport master (
    output in_valid, in_alu_op, in_dest, in_src1, in_src2, in_src3,
           in_src_en, in_mul, wait_load_signal, load_destination,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_alu_op, in_dest, in_src1, in_src2, in_src3,
           in_src_en, in_mul, wait_load_signal, load_destination,
    output in_ready
  );
endinterface

// File: rtl/vex_wb_slot_table.sv
// Writeback slot table: shifts one position toward the port every cycle,
// accepts one insert per cycle at a chosen (post-shift) position, exports position 1.
module vex_wb_slot_table
  import vex_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int PW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ins_en_i,
  input  logic [PW-1:0]   ins_pos_i,
  input  vreg_t           ins_dest_i,
  output slot_t           head_o,
  output logic [DEPTH:1]  occ_o
);

  slot_t slot_q [1:DEPTH];
  slot_t slot_d [1:DEPTH];

  always_comb begin
    for (int k = 1; k < DEPTH; k++) begin
      slot_d[k] = slot_q[k+1];
    end
    slot_d[DEPTH] = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (ins_en_i && (int'(ins_pos_i) == k)) begin
        slot_d[k] = '{vld: 1'b1, dest: ins_dest_i};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      slot_q <= slot_d;
    end
  end

  always_comb begin
    for (int k = 1; k <= DEPTH; k++) begin
      occ_o[k] = slot_q[k].vld;
    end
  end

  assign head_o = slot_q[1];

endmodule

// File: rtl/vex_issue_ctrl.sv
// Vector issue scheduler: busy-register scoreboard, load and writeback-port hazard
// checks, single-op-per-cycle release into the lane execution stage.
module vex_issue_ctrl
  import vex_issue_ctrl_pkg::*;
#(
  parameter int MICROOP_BIT = 9,
  parameter int ALU_LAT     = 1,
  parameter int MUL_LAT     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  vex_issue_ctrl_if.slave        up,
  output logic                   issue_valid,
  output logic                   issue_mul,
  output logic [MICROOP_BIT-1:0] issue_alu_op,
  output vreg_t                  issue_dest,
  output logic                   wb_valid,
  output vreg_t                  wb_dest,
  output logic [VREG_COUNT-1:0]  busy_vec,
  output logic [15:0]            stall_cnt
);

  localparam int DEPTH = MUL_LAT + 1;
  localparam int PW    = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] POS_ALU = PW'(ALU_LAT + 1);
  localparam logic [PW-1:0] POS_MUL = PW'(MUL_LAT + 1);

  slot_t                  head;
  logic [DEPTH:1]         occ;
  logic                   no_raw, no_waw, no_load, slot_free, ld_hit;
  logic                   ready, fire;
  logic [VREG_COUNT-1:0]  busy_q, busy_d;
  logic [15:0]            stall_q, stall_d;
  logic                   iv_q, imul_q;
  logic [MICROOP_BIT-1:0] iop_q;
  vreg_t                  idest_q;

  vex_wb_slot_table #(.DEPTH(DEPTH), .PW(PW)) u_slots (
    .clk        (clk),
    .rst        (rst),
    .ins_en_i   (fire),
    .ins_pos_i  (up.in_mul ? POS_MUL : POS_ALU),
    .ins_dest_i (up.in_dest),
    .head_o     (head),
    .occ_o      (occ)
  );

  // Hazard terms look only at registered state and the presented fields.
  always_comb begin
    no_raw = !((up.in_src_en[0] && busy_q[up.in_src1]) ||
               (up.in_src_en[1] && busy_q[up.in_src2]) ||
               (up.in_src_en[2] && busy_q[up.in_src3]));
    no_waw = !busy_q[up.in_dest];
    ld_hit = (up.in_dest == up.load_destination) ||
             (up.in_src_en[0] && (up.in_src1 == up.load_destination)) ||
             (up.in_src_en[1] && (up.in_src2 == up.load_destination)) ||
             (up.in_src_en[2] && (up.in_src3 == up.load_destination));
    no_load = !(up.wait_load_signal && ld_hit);
    // A multiply lands beyond every live slot, so only ALU ops can collide.
    slot_free = up.in_mul || !occ[ALU_LAT+2];
    ready = rst && no_raw && no_waw && no_load && slot_free;
    fire  = up.in_valid && ready;
  end

  assign up.in_ready = ready;

  always_comb begin
    busy_d = busy_q;
    if (head.vld) busy_d[head.dest] = 1'b0;
    if (fire)     busy_d[up.in_dest] = 1'b1;
    stall_d = stall_q;
    if (up.in_valid && !ready && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q  <= '0;
      stall_q <= '0;
      iv_q    <= 1'b0;
      imul_q  <= 1'b0;
      iop_q   <= '0;
      idest_q <= '0;
    end else begin
      busy_q  <= busy_d;
      stall_q <= stall_d;
      iv_q    <= fire;
      imul_q  <= fire && up.in_mul;
      if (fire) begin
        iop_q   <= up.in_alu_op;
        idest_q <= up.in_dest;
      end
    end
  end

  assign issue_valid  = iv_q;
  assign issue_mul    = imul_q;
  assign issue_alu_op = iop_q;
  assign issue_dest   = idest_q;
  assign wb_valid     = head.vld;
  assign wb_dest      = head.dest;
  assign busy_vec     = busy_q;
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_vex_issue_ctrl.sv
// Bench for vex_issue_ctrl: per-scenario tasks plus a writeback/issue scoreboard.
module tb_vex_issue_ctrl;
  import vex_issue_ctrl_pkg::*;

  localparam int ALU_LAT = 1;
  localparam int MUL_LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vex_issue_ctrl_if #(.MICROOP_BIT(9)) up ();

  logic        issue_valid, issue_mul, wb_valid;
  logic [8:0]  issue_alu_op;
  vreg_t       issue_dest, wb_dest;
  logic [31:0] busy_vec;
  logic [15:0] stall_cnt;

  vex_issue_ctrl #(.MICROOP_BIT(9), .ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .up           (up.slave),
    .issue_valid  (issue_valid),
    .issue_mul    (issue_mul),
    .issue_alu_op (issue_alu_op),
    .issue_dest   (issue_dest),
    .wb_valid     (wb_valid),
    .wb_dest      (wb_dest),
    .busy_vec     (busy_vec),
    .stall_cnt    (stall_cnt)
  );

  typedef struct {
    logic [4:0] dest;
    int         cyc;
  } wb_exp_t;

  wb_exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int wb_seen  = 0;
  int exp_stall = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard: every fire predicts one writeback at fire_cycle+1+L and an issue pulse next cycle.
  initial begin : monitor
    logic       exp_iv, exp_imul;
    logic [8:0] exp_op;
    logic [4:0] exp_dest;
    wb_exp_t    e;
    exp_iv = 1'b0; exp_imul = 1'b0; exp_op = '0; exp_dest = '0;
    forever begin
      @(negedge clk);
      if (wb_valid === 1'b1) begin
        wb_seen++;
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL wb_unexpected: dest=%0d cyc=%0d, required no writeback", wb_dest, cyc);
        end else begin
          e = sb.pop_front();
          if (wb_dest !== e.dest || cyc !== e.cyc)
            $display("FAIL wb_order: dest=%0d cyc=%0d, required dest=%0d cyc=%0d", wb_dest, cyc, e.dest, e.cyc);
          else n_pass++;
        end
      end
      n_checks++;
      if (issue_valid !== exp_iv || issue_mul !== exp_imul)
        $display("FAIL issue_flags: valid=%b mul=%b, required valid=%b mul=%b cyc=%0d", issue_valid, issue_mul, exp_iv, exp_imul, cyc);
      else n_pass++;
      if (exp_iv) begin
        n_checks++;
        if (issue_dest !== exp_dest || issue_alu_op !== exp_op)
          $display("FAIL issue_fields: dest=%0d op=%h, required dest=%0d op=%h", issue_dest, issue_alu_op, exp_dest, exp_op);
        else n_pass++;
      end
      if (rst && up.in_valid && up.in_ready) begin
        e.dest = up.in_dest;
        e.cyc  = cyc + 1 + (up.in_mul ? MUL_LAT : ALU_LAT);
        sb.push_back(e);
        exp_iv = 1'b1; exp_imul = up.in_mul; exp_op = up.in_alu_op; exp_dest = up.in_dest;
      end else begin
        exp_iv = 1'b0; exp_imul = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [8:0] op, input logic [4:0] d, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [4:0] s3, input logic [2:0] en,
                          input logic mul);
    up.in_valid = 1'b1; up.in_alu_op = op; up.in_dest = d;
    up.in_src1 = s1; up.in_src2 = s2; up.in_src3 = s3;
    up.in_src_en = en; up.in_mul = mul;
  endtask

  task automatic idle();
    up.in_valid = 1'b0;
    up.in_mul   = 1'b0;
  endtask

  task automatic drain_and_check(input string name);
    repeat (8) tick();
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0 || busy_vec !== 32'd0)
      $display("FAIL %s_drain: pending=%0d busy=%h, required pending=0 busy=0", name, sb.size(), busy_vec);
    else n_pass++;
    n_checks++;
    if (stall_cnt !== 16'(exp_stall))
      $display("FAIL %s_stall_cnt: %0d, required %0d", name, stall_cnt, exp_stall);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    up.wait_load_signal = 1'b0; up.load_destination = 5'd0;
    drive_op(9'h011, 5'd3, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0);
    repeat (2) tick();
    @(negedge clk);
    n_checks++;
    if (up.in_ready !== 1'b0) $display("FAIL reset_ready: %b, required 0", up.in_ready);
    else n_pass++;
    n_checks++;
    if (busy_vec !== 32'd0 || wb_valid !== 1'b0 || stall_cnt !== 16'd0 ||
        issue_alu_op !== 9'd0 || issue_dest !== 5'd0)
      $display("FAIL reset_state: busy=%h wb=%b stall=%0d op=%h dest=%0d, required all 0",
               busy_vec, wb_valid, stall_cnt, issue_alu_op, issue_dest);
    else n_pass++;
    tick();
    idle();
    rst = 1'b1;
  endtask

  task automatic test_alu_stream();
    for (int i = 1; i <= 4; i++) begin
      drive_op(9'h100 + 9'(i), 5'(i), 5'd0, 5'd0, 5'd0, 3'b000, 1'b0);
      @(negedge clk);
      n_checks++;
      if (up.in_ready !== 1'b1) $display("FAIL stream_ready[%0d]: %b, required 1", i, up.in_ready);
      else n_pass++;
      tick();
    end
    idle();
    drain_and_check("stream");
  endtask

  task automatic test_mul_collision();
    drive_op(9'h055, 5'd5, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1);
    @(negedge clk);
    n_checks++;
    if (up.in_ready !== 1'b1) $display("FAIL mul_ready: %b, required 1", up.in_ready);
    else n_pass++;
    tick();
    idle();
    tick();
    tick();
    drive_op(9'h066, 5'd6, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0);
    @(negedge clk);
    n_checks++;
    if (up.in_ready !== 1'b0) $display("FAIL collision_hold: ready=%b, required 0", up.in_ready);
    else n_pass++;
    exp_stall++;
    tick();
    @(negedge clk);
    n_checks++;
    if (up.in_ready !== 1'b1) $display("FAIL collision_release: ready=%b, required 1", up.in_ready);
    else n_pass++;
    tick();
    idle();
    drain_and_check("collision");
  endtask

  task automatic test_raw();
    drive_op(9'h077, 5'd7, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0);
    tick();
    drive_op(9'h088, 5'd8, 5'd7, 5'd0, 5'd0, 3'b001, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (up.in_ready !== 1'b0 || busy_vec[7] !== 1'b1)
        $display("FAIL raw_hold[%0d]: ready=%b busy7=%b, required ready=0 busy7=1", k, up.in_ready, busy_vec[7]);
      else n_pass++;
      exp_stall++;
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (up.in_ready !== 1'b1 || busy_vec[7] !== 1'b0)
      $display("FAIL raw_release: ready=%b busy7=%b, required ready=1 busy7=0", up.in_ready, busy_vec[7]);
    else n_pass++;
    tick();
    idle();
    drain_and_check("raw");
  endtask

  task automatic test_load();
    up.wait_load_signal = 1'b1;
    up.load_destination = 5'd9;
    // src3 matches the load but is not enabled, so this op must pass.
    drive_op(9'h0C0, 5'd12, 5'd1, 5'd2, 5'd9, 3'b011, 1'b0);
    @(negedge clk);
    n_checks++;
    if (up.in_ready !== 1'b1) $display("FAIL load_masked_src: ready=%b, required 1", up.in_ready);
    else n_pass++;
    tick();
    drive_op(9'h0B0, 5'd11, 5'd0, 5'd9, 5'd0, 3'b010, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (up.in_ready !== 1'b0) $display("FAIL load_hold[%0d]: ready=%b, required 0", k, up.in_ready);
      else n_pass++;
      exp_stall++;
      tick();
    end
    up.wait_load_signal = 1'b0;
    @(negedge clk);
    n_checks++;
    if (up.in_ready !== 1'b1) $display("FAIL load_release: ready=%b, required 1", up.in_ready);
    else n_pass++;
    tick();
    idle();
    drain_and_check("load");
  endtask

  task automatic test_waw();
    drive_op(9'h0A0, 5'd10, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1);
    tick();
    drive_op(9'h0A1, 5'd10, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0);
    for (int k = 1; k <= MUL_LAT + 1; k++) begin
      @(negedge clk);
      n_checks++;
      if (up.in_ready !== 1'b0 || busy_vec[10] !== 1'b1)
        $display("FAIL waw_hold[%0d]: ready=%b busy10=%b, required ready=0 busy10=1", k, up.in_ready, busy_vec[10]);
      else n_pass++;
      exp_stall++;
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (up.in_ready !== 1'b1) $display("FAIL waw_release: ready=%b, required 1", up.in_ready);
    else n_pass++;
    tick();
    idle();
    drain_and_check("waw");
  endtask

  task automatic test_reset_inflight();
    int wb_before;
    drive_op(9'h0D0, 5'd13, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1);
    tick();
    drive_op(9'h0D1, 5'd14, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1);
    tick();
    drive_op(9'h0D2, 5'd15, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0);
    tick();
    idle();
    rst = 1'b0;
    tick();
    sb.delete();
    exp_stall = 0;
    wb_before = wb_seen;
    @(negedge clk);
    n_checks++;
    if (busy_vec !== 32'd0 || wb_valid !== 1'b0 || issue_valid !== 1'b0 || stall_cnt !== 16'd0)
      $display("FAIL reset_flush: busy=%h wb=%b iv=%b stall=%0d, required all 0",
               busy_vec, wb_valid, issue_valid, stall_cnt);
    else n_pass++;
    tick();
    rst = 1'b1;
    repeat (8) tick();
    n_checks++;
    if (wb_seen !== wb_before) $display("FAIL reset_no_wb: %0d pulses, required 0", wb_seen - wb_before);
    else n_pass++;
  endtask

  initial begin
    up.in_valid = 1'b0; up.in_alu_op = '0; up.in_dest = '0;
    up.in_src1 = '0; up.in_src2 = '0; up.in_src3 = '0;
    up.in_src_en = '0; up.in_mul = 1'b0;
    up.wait_load_signal = 1'b0; up.load_destination = '0;
    test_reset();
    test_alu_stream();
    test_mul_collision();
    test_raw();
    test_load();
    test_waw();
    test_reset_inflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vex_issue_ctrl.md
# vex_issue_ctrl

Issue scheduler in front of the vector lane execution stage. Accepts decoded micro-ops over a valid/ready handshake and releases at most one per cycle to the execution stage. Blocks an op when a hazard is detected:
- RAW/WAW on the 32-entry vector register file, via a busy scoreboard;
- a pending load destination;
- a collision on the single writeback port between 1-cycle ALU ops and multi-cycle multiplications.

Also publishes a predicted writeback stream for the scoreboard and the hazard logic.

## Interface
Parameters:
- MICROOP_BIT, 9: width of the ALU micro-op field.
- ALU_LAT, 1: cycles from issue_valid to the writeback of a non-multiply op.
- MUL_LAT, 4: cycles from issue_valid to the writeback of a multiply; MUL_LAT > ALU_LAT.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, active-low, synchronous; sampled only on the rising clk edge.
- in_valid  in  1  micro-op presented.
- in_ready  out  1  micro-op accepted this cycle when in_valid is also high ("fire").
- in_alu_op  in  MICROOP_BIT  micro-op code, forwarded unchanged.
- in_dest  in  5  destination vector register.
- in_src1, in_src2, in_src3  in  5 each  source registers.
- in_src_en  in  3  per-source use bit; bit0 = src1, bit1 = src2, bit2 = src3.
- in_mul  in  1  op is a multiplication.
- wait_load_signal  in  1  a vector load is outstanding.
- load_destination  in  5  destination of the outstanding load.
- issue_valid  out  1  registered; drives the execution stage write-back-enable.
- issue_mul  out  1  registered; drives the multiplication flag.
- issue_alu_op  out  MICROOP_BIT  registered micro-op.
- issue_dest  out  5  registered destination.
- wb_valid  out  1  predicted writeback occurs this cycle.
- wb_dest  out  5  register written by that writeback.
- busy_vec  out  32  scoreboard; bit r set means register r has a result in flight.
- stall_cnt  out  16  saturating count of cycles with in_valid=1 and in_ready=0.

## Operation
- Latency of the presented op: L = MUL_LAT if in_mul, else ALU_LAT.
- Slot table: positions 1..MUL_LAT+1, each holding a valid bit and a 5-bit dest.
  - Every cycle, position k+1 shifts to position k.
  - Position 1 is exported as wb_valid/wb_dest.
- On fire, the op is written into position L+1 of the post-shift table.
- in_ready = no_raw AND no_waw AND no_load AND slot_free. Each term is computed from registered state and the presented fields only; none depends on in_valid.
  - no_raw: busy_vec[src_i]==0 for every enabled source.
  - no_waw: busy_vec[in_dest]==0.
  - no_load: !(wait_load_signal and (in_dest or any enabled source) == load_destination).
  - slot_free: post-shift position L+1 is empty, i.e. current position L+2 is empty. Position MUL_LAT+2 is treated as always empty.
- Scoreboard update:
  - fire sets busy_vec[in_dest];
  - a slot leaving position 1 clears busy_vec[wb_dest].
  - There is no bypass: a register retiring in cycle t is still busy for a request presented in cycle t.
- issue_* outputs load on every cycle: issue_valid <= fire, and the other fields load on fire. When fire=0, issue_mul is cleared and issue_alu_op/issue_dest hold their values.
- stall_cnt increments when in_valid && !in_ready and saturates at 16'hFFFF.

## Timing
- Op firing at edge t:
  - issue_valid is high in cycle t+1;
  - wb_valid is high in cycle t+1+L;
  - busy_vec[dest] is set from cycle t+1 through cycle t+1+L inclusive, and clear from t+2+L.
- Throughput: one op per cycle when there are no hazards. Back-to-back ALU ops never collide with each other.
- A multiply fired at t reserves writeback cycle t+1+MUL_LAT. An ALU op whose writeback would land in that cycle is held exactly one cycle.
- Simultaneous fire and retirement of different registers: both the set and the clear take effect on the same edge.
- Reset (rst=0 at an edge):
  - all slots, busy_vec, issue_valid, issue_mul, wb_valid and stall_cnt go to 0;
  - issue_alu_op and issue_dest go to 0.
  - In-flight ops are discarded; the execution stage is reset with the same signal.
  - in_ready is 0 while rst=0.

## Structure
- The shared vector package gains a typedef for the slot entry (valid, dest) and the constants VREG_COUNT=32 and VREG_ADDR=5.
- One sub-module, vex_wb_slot_table: the shift register, position-indexed insert, and position-1 export.
- The scoreboard and the hazard check stay in the top module.

## Test plan
- Independent ALU ops to v1..v4 on 4 consecutive cycles -> in_ready stays 1; wb_valid in cycles t+2..t+5 with wb_dest 1,2,3,4.
- Multiply to v5 fired at t=0, then an ALU op to v6 presented from t=3 -> v6 stalls at t=3 (its writeback would land in cycle 5, the multiply's slot) and fires at t=4; v5 writes back in cycle 5, v6 in cycle 6, stall_cnt=1.
- ALU op to v7 fired at t=0, then an op reading src1=v7 -> in_ready=0 through cycle 2; fires in cycle 3.
- wait_load_signal=1, load_destination=9, op with in_src_en=3'b010 and src2=9 -> held until wait_load_signal drops, then fires the same cycle.
- Multiply to v10 in flight, an op with dest v10 presented -> WAW stall until busy_vec[10] clears.
- rst=0 asserted with three ops in flight -> next cycle busy_vec=0, wb_valid=0, issue_valid=0, stall_cnt=0; no wb_valid pulses afterwards.
